// File: rtl/ov7670_pkg.sv
// Shared types and geometry for the frame downscaler and the inference core.
// DOWNSCALE_INVERT_EN selects inverted output polarity.
package ov7670_pkg;

  typedef enum logic [2:0] {IDLE, READ, DRAIN, WRITE, DONE} ds_state_t;

  localparam int SRC_ADDR_W = 19;
  localparam int OUT_ADDR_W = 10;
  localparam int PIX_W      = 8;

  localparam int DEF_SRC_W    = 640;
  localparam int DEF_SRC_H    = 480;
  localparam int DEF_BLK_LOG2 = 4;
  localparam int DEF_OUT_W    = 28;
  localparam int DEF_OUT_H    = 28;
  localparam int DEF_X0       = 96;
  localparam int DEF_Y0       = 16;
  localparam int DEF_RD_LAT   = 1;

  // Dark-on-light camera digits become light-on-dark when inversion is enabled.
  function automatic logic [PIX_W-1:0] ds_polarity(input logic [PIX_W-1:0] avg);
`ifdef DOWNSCALE_INVERT_EN
    return ~avg;
`else
    return avg;
`endif
  endfunction

endpackage

// File: rtl/ds_addr_gen.sv
// Block/pixel counters and incremental source address for the frame downscaler.
module ds_addr_gen import ov7670_pkg::*; #(
  parameter int SRC_W    = DEF_SRC_W,
  parameter int BLK_LOG2 = DEF_BLK_LOG2,
  parameter int OUT_W    = DEF_OUT_W,
  parameter int OUT_H    = DEF_OUT_H,
  parameter int X0       = DEF_X0,
  parameter int Y0       = DEF_Y0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init,
  input  logic                  step,
  input  logic                  next_pix,
  output logic [SRC_ADDR_W-1:0] addr,
  output logic [OUT_ADDR_W-1:0] pix_idx,
  output logic                  last_sample,
  output logic                  last_pixel
);

  localparam int BLK = 1 << BLK_LOG2;
  localparam logic [SRC_ADDR_W-1:0] BASE0    = SRC_ADDR_W'(Y0 * SRC_W + X0);
  localparam logic [SRC_ADDR_W-1:0] ROW_ADV  = SRC_ADDR_W'(SRC_W - (BLK - 1));
  localparam logic [SRC_ADDR_W-1:0] BLK_ADV  = SRC_ADDR_W'(BLK);
  localparam logic [SRC_ADDR_W-1:0] BAND_ADV = SRC_ADDR_W'(BLK * SRC_W - (OUT_W - 1) * BLK);

  logic [BLK_LOG2-1:0]   bx, by;
  logic [OUT_ADDR_W-1:0] ox, oy;
  logic [SRC_ADDR_W-1:0] pix_base, nxt_base;
  logic                  last_col;

  assign last_col    = (ox == OUT_ADDR_W'(OUT_W - 1));
  assign last_sample = (&bx) && (&by);
  assign last_pixel  = last_col && (oy == OUT_ADDR_W'(OUT_H - 1));

  always_comb begin
    nxt_base = pix_base + BLK_ADV;
    if (last_col) nxt_base = pix_base + BAND_ADV;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bx       <= '0;
      by       <= '0;
      ox       <= '0;
      oy       <= '0;
      pix_idx  <= '0;
      pix_base <= '0;
      addr     <= '0;
    end else if (init) begin
      bx       <= '0;
      by       <= '0;
      ox       <= '0;
      oy       <= '0;
      pix_idx  <= '0;
      pix_base <= BASE0;
      addr     <= BASE0;
    end else if (next_pix) begin
      bx       <= '0;
      by       <= '0;
      pix_idx  <= pix_idx + 1'b1;
      pix_base <= nxt_base;
      addr     <= nxt_base;
      if (last_col) begin
        ox <= '0;
        oy <= oy + 1'b1;
      end else begin
        ox <= ox + 1'b1;
      end
    end else if (step) begin
      // Row step inside a block: jump from column 15 back to column 0 of the next row.
      if (&bx) begin
        bx   <= '0;
        by   <= by + 1'b1;
        addr <= addr + ROW_ADV;
      end else begin
        bx   <= bx + 1'b1;
        addr <= addr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_downscaler.sv
// Box-averages a centred crop of the captured luma frame into the LeNet input RAM.
// DOWNSCALE_INVERT_EN selects dout = 255 - average.
module frame_downscaler import ov7670_pkg::*; #(
  parameter int SRC_W    = DEF_SRC_W,
  parameter int SRC_H    = DEF_SRC_H,
  parameter int BLK_LOG2 = DEF_BLK_LOG2,
  parameter int OUT_W    = DEF_OUT_W,
  parameter int OUT_H    = DEF_OUT_H,
  parameter int X0       = DEF_X0,
  parameter int Y0       = DEF_Y0,
  parameter int RD_LAT   = DEF_RD_LAT
) (
  input  logic                  clk25,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [SRC_ADDR_W-1:0] addr_src,
  input  logic [PIX_W-1:0]      din,
  output logic [OUT_ADDR_W-1:0] addr_out,
  output logic [PIX_W-1:0]      dout,
  output logic                  we
);

  localparam int SH    = 2 * BLK_LOG2;
  localparam int ACC_W = PIX_W + SH;
  localparam logic [ACC_W-1:0] HALF = ACC_W'(2 ** (SH - 1));

  if (X0 + OUT_W * (1 << BLK_LOG2) > SRC_W) begin : g_bad_x
    $fatal(1, "frame_downscaler: crop exceeds SRC_W");
  end
  if (Y0 + OUT_H * (1 << BLK_LOG2) > SRC_H) begin : g_bad_y
    $fatal(1, "frame_downscaler: crop exceeds SRC_H");
  end
  if (RD_LAT < 1 || RD_LAT > 2) begin : g_bad_lat
    $fatal(1, "frame_downscaler: RD_LAT must be 1 or 2");
  end
  if (OUT_W * OUT_H > 1024) begin : g_bad_out
    $fatal(1, "frame_downscaler: output exceeds result RAM");
  end

  ds_state_t             state;
  logic [ACC_W-1:0]      acc, acc_nxt, rnd;
  logic [PIX_W-1:0]      avg;
  logic [RD_LAT-1:0]     vld;
  logic [1:0]            drn;
  logic                  init, step, next_pix, last_sample, last_pixel;
  logic [OUT_ADDR_W-1:0] pix_idx;

  assign init     = (state == IDLE) && start;
  assign step     = (state == READ) && !last_sample;
  assign next_pix = (state == WRITE) && !last_pixel;

  ds_addr_gen #(
    .SRC_W   (SRC_W),
    .BLK_LOG2(BLK_LOG2),
    .OUT_W   (OUT_W),
    .OUT_H   (OUT_H),
    .X0      (X0),
    .Y0      (Y0)
  ) u_addr_gen (
    .clk        (clk25),
    .rst        (rst),
    .init       (init),
    .step       (step),
    .next_pix   (next_pix),
    .addr       (addr_src),
    .pix_idx    (pix_idx),
    .last_sample(last_sample),
    .last_pixel (last_pixel)
  );

  // The final sample lands on the same edge that enters WRITE, so round from acc_nxt.
  always_comb begin
    acc_nxt = acc;
    if (vld[RD_LAT-1]) acc_nxt = acc + ACC_W'(din);
    rnd = acc_nxt + HALF;
    avg = PIX_W'(rnd >> SH);
  end

  always_ff @(posedge clk25) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      we       <= 1'b0;
      addr_out <= '0;
      dout     <= '0;
      acc      <= '0;
      vld      <= '0;
      drn      <= '0;
    end else begin
      vld[0] <= (state == READ);
      for (int unsigned i = 1; i < RD_LAT; i++) vld[i] <= vld[i-1];
      acc  <= acc_nxt;
      we   <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          acc <= '0;
          if (start) begin
            state <= READ;
            busy  <= 1'b1;
          end
        end
        READ: begin
          if (last_sample) begin
            state <= DRAIN;
            drn   <= '0;
          end
        end
        DRAIN: begin
          drn <= drn + 1'b1;
          if (drn == 2'(RD_LAT - 1)) begin
            state    <= WRITE;
            we       <= 1'b1;
            addr_out <= pix_idx;
            dout     <= ds_polarity(avg);
            acc      <= '0;
          end
        end
        WRITE: begin
          if (last_pixel) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state <= READ;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_downscaler.sv
// Self-checking bench: reduced output geometry, full 640x480 source map and crop origin.
module tb_frame_downscaler;

  localparam int SRC_W = 640;
  localparam int SRC_H = 480;
  localparam int X0    = 96;
  localparam int Y0    = 16;
  localparam int BLK   = 16;
  localparam int AW = 4, AH = 3, NA = AW * AH;
  localparam int BW = 3, BH = 2, NB = BW * BH;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start_a, start_b;
  logic        busy_a, done_a, we_a, busy_b, done_b, we_b;
  logic [18:0] addr_src_a, addr_src_b;
  logic [7:0]  din_a, din_b, b_stage;
  logic [9:0]  addr_out_a, addr_out_b;
  logic [7:0]  dout_a, dout_b;

  logic [7:0] src_mem [SRC_W*SRC_H];

  always @(posedge clk) din_a <= src_mem[addr_src_a];
  always @(posedge clk) begin
    b_stage <= src_mem[addr_src_b];
    din_b   <= b_stage;
  end

  frame_downscaler #(.OUT_W(AW), .OUT_H(AH), .RD_LAT(1)) dut_a (
    .clk25(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
    .addr_src(addr_src_a), .din(din_a), .addr_out(addr_out_a), .dout(dout_a), .we(we_a));

  frame_downscaler #(.OUT_W(BW), .OUT_H(BH), .RD_LAT(2)) dut_b (
    .clk25(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
    .addr_src(addr_src_b), .din(din_b), .addr_out(addr_out_b), .dout(dout_b), .we(we_b));

  int wr_cnt_a = 0, wr_cnt_b = 0, done_cnt_a = 0, done_cnt_b = 0;
  int wr_addr_a [4096], wr_val_a [4096], wr_addr_b [4096], wr_val_b [4096];

  always @(negedge clk) begin
    if (we_a) begin
      wr_addr_a[wr_cnt_a] = int'(addr_out_a);
      wr_val_a[wr_cnt_a]  = int'(dout_a);
      wr_cnt_a++;
    end
    if (done_a) done_cnt_a++;
    if (we_b) begin
      wr_addr_b[wr_cnt_b] = int'(addr_out_b);
      wr_val_b[wr_cnt_b]  = int'(dout_b);
      wr_cnt_b++;
    end
    if (done_b) done_cnt_b++;
  end

  int n_pass = 0, n_tot = 0;
  int exp_pix [1024];

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic int pol(input int v);
`ifdef DOWNSCALE_INVERT_EN
    return 255 - v;
`else
    return v;
`endif
  endfunction

  task automatic fill(input int mode, input int val);
    for (int i = 0; i < SRC_W * SRC_H; i++) begin
      case (mode)
        0:       src_mem[i] = 8'(val);
        1:       src_mem[i] = 8'(i % SRC_W);
        default: src_mem[i] = 8'($urandom);
      endcase
    end
  endtask

  // Reference: plain block sum over the crop, round half up, optional inversion.
  task automatic model(input int w, input int h);
    for (int oy = 0; oy < h; oy++)
      for (int ox = 0; ox < w; ox++) begin
        int sum = 0;
        for (int y = 0; y < BLK; y++)
          for (int x = 0; x < BLK; x++)
            sum += int'(src_mem[(Y0 + oy*BLK + y) * SRC_W + X0 + ox*BLK + x]);
        exp_pix[oy*w + ox] = pol((sum + 128) / 256);
      end
  endtask

  function automatic bit cur_busy(input bit sel); return sel ? busy_b : busy_a; endfunction
  function automatic bit cur_done(input bit sel); return sel ? done_b : done_a; endfunction
  function automatic int cur_wr(input bit sel);   return sel ? wr_cnt_b : wr_cnt_a; endfunction
  function automatic int cur_dn(input bit sel);   return sel ? done_cnt_b : done_cnt_a; endfunction

  task automatic set_start(input bit sel, input bit v);
    if (sel) start_b = v; else start_a = v;
  endtask

  task automatic run(input bit sel, input int n, input int lat_exp,
                     input int second_at, input bit start_at_done);
    int lat, wbase, dbase;
    bit busy_ok;
    wbase = cur_wr(sel);
    dbase = cur_dn(sel);
    @(negedge clk); set_start(sel, 1'b1);
    @(posedge clk); #1 set_start(sel, 1'b0);
    busy_ok = cur_busy(sel);
    lat = 0;
    while (lat < lat_exp + 100) begin
      @(posedge clk); #1;
      lat++;
      set_start(sel, lat == second_at);
      if (!cur_busy(sel)) busy_ok = 1'b0;
      if (cur_done(sel)) break;
    end
    set_start(sel, 1'b0);
    chk("done_latency", lat, lat_exp);
    chk("busy_held", int'(busy_ok), 1);
    if (start_at_done) set_start(sel, 1'b1);
    @(posedge clk); #1 set_start(sel, 1'b0);
    chk("busy_after_done", int'(cur_busy(sel)), 0);
    @(negedge clk);
    chk("write_count", cur_wr(sel) - wbase, n);
    chk("done_count", cur_dn(sel) - dbase, 1);
    for (int i = 0; i < n; i++) begin
      chk("addr_out_order", sel ? wr_addr_b[wbase+i] : wr_addr_a[wbase+i], i);
      chk("dout", sel ? wr_val_b[wbase+i] : wr_val_a[wbase+i], exp_pix[i]);
    end
  endtask

  typedef struct {
    int mode;
    int val;
    int exp00;
  } vec_t;
  vec_t tbl [6];

  initial begin
    int wsnap, dsnap;
    tbl[0] = '{mode: 0, val: 128, exp00: pol(128)};
    tbl[1] = '{mode: 1, val: 0,   exp00: pol(104)};
    tbl[2] = '{mode: 0, val: 255, exp00: pol(255)};
    tbl[3] = '{mode: 0, val: 0,   exp00: pol(0)};
    tbl[4] = '{mode: 2, val: 0,   exp00: -1};
    tbl[5] = '{mode: 2, val: 0,   exp00: -1};

    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_done", int'(done_a), 0);
    chk("rst_we", int'(we_a), 0);
    chk("rst_addr_src", int'(addr_src_a), 0);
    chk("rst_addr_out", int'(addr_out_a), 0);
    chk("rst_dout", int'(dout_a), 0);
    chk("rst_busy_b", int'(busy_b), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int t = 0; t < 6; t++) begin
      wsnap = wr_cnt_a;
      fill(tbl[t].mode, tbl[t].val);
      model(AW, AH);
      run(1'b0, NA, NA * 258, -1, 1'b0);
      if (tbl[t].exp00 >= 0) chk("table_pix00", wr_val_a[wsnap], tbl[t].exp00);
      if (tbl[t].mode == 1) chk("column_pix30", wr_val_a[wsnap+3], pol(152));
    end

    // Extra start mid-run and start coinciding with done are both ignored.
    fill(2, 0);
    model(AW, AH);
    run(1'b0, NA, NA * 258, 1000, 1'b1);

    // Reset mid-run: outputs return to reset values, nothing further is written.
    fill(1, 0);
    @(negedge clk); start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    repeat (1500) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    wsnap = wr_cnt_a;
    dsnap = done_cnt_a;
    chk("midrst_busy", int'(busy_a), 0);
    chk("midrst_we", int'(we_a), 0);
    chk("midrst_done", int'(done_a), 0);
    chk("midrst_addr_src", int'(addr_src_a), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    chk("midrst_no_writes", wr_cnt_a - wsnap, 0);
    chk("midrst_no_done", done_cnt_a - dsnap, 0);
    chk("midrst_idle", int'(busy_a), 0);
    fill(2, 0);
    model(AW, AH);
    run(1'b0, NA, NA * 258, -1, 1'b0);

    // Two-cycle source RAM.
    fill(0, 128);
    model(BW, BH);
    run(1'b1, NB, NB * 259, -1, 1'b0);
    chk("lat2_pix0", wr_val_b[wr_cnt_b - NB], pol(128));
    fill(2, 0);
    model(BW, BH);
    run(1'b1, NB, NB * 259, -1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
